text_screen_sequencer: RTL and testbench
========================================

Name: text_screen_sequencer

Overview:
- Sequences the full-screen text overlays: game-over text and final/level-complete text.
- Decides which overlay is shown and when, and ramps a fade level in and out over frames.
- Freezes gameplay while text is up and issues a restart pulse when the player dismisses it.
- Sits between game logic and the text ROM/palette datapath; the downstream video mux uses text_sel, overlay_en and fade_level to scale palette output.

Parameters:
- STEP_FRAMES, 4, frame ticks per fade-level step (legal range 1..255)
- HOLD_FRAMES, 120, minimum frame ticks at full intensity before dismissal is accepted (legal range 1..1023)

Ports:
- vga_clk  input  1  pixel clock; all state on posedge
- reset_n  input  1  asynchronous active-low reset
- DrawX  input  10  current pixel column
- DrawY  input  10  current pixel row
- game_over  input  1  single-cycle event pulse from game logic
- level_done  input  1  single-cycle event pulse from game logic
- start_btn  input  1  raw asynchronous button, active-high
- text_sel  output  2  0=none, 1=GAME_OVER text, 2=FINAL text
- overlay_en  output  1  overlay pixels to be muxed over game video
- fade_level  output  4  overlay intensity, 0..15
- game_pause  output  1  gameplay frozen
- restart  output  1  single-cycle pulse: game logic resets level

Behaviour:
- Reset (async assert, sync release): state=PLAY, text_sel=0, overlay_en=0, fade_level=0, game_pause=0, restart=0, all counters 0, synchronizer flops 0.
- frame_tick: one-cycle internal pulse, registered. Asserts on the first cycle where DrawX==0 && DrawY==0, after the condition was false the previous cycle. Exactly one tick per frame.
- start_btn: 2-FF synchronizer, then rising-edge detect giving btn_press, a one-cycle pulse. Total latency 3 cycles from raw assertion.
- PLAY:
  - outputs as at reset.
  - game_over -> FADE_IN with text_sel=1; level_done -> FADE_IN with text_sel=2. Both take effect on the next clock edge and do not wait for frame_tick.
  - Simultaneous game_over and level_done: game_over wins (text_sel=1).
- FADE_IN:
  - overlay_en=1, game_pause=1, fade_level starts at 0.
  - step counter counts frame_ticks. On the STEP_FRAMES-th tick, fade_level increments and the step counter clears.
  - When fade_level becomes 15 -> HOLD, hold counter cleared. Full fade takes 15*STEP_FRAMES ticks.
- HOLD:
  - fade_level=15. hold counter counts frame_ticks and saturates at HOLD_FRAMES.
  - btn_press when hold counter==HOLD_FRAMES -> FADE_OUT, step counter cleared.
  - btn_press before then is ignored and not queued.
- FADE_OUT:
  - fade_level decrements every STEP_FRAMES ticks.
  - When fade_level becomes 0 -> PLAY. In that same transition: text_sel=0, overlay_en=0, game_pause=0, restart=1 for exactly one cycle.
- Events (game_over, level_done) in any state other than PLAY are ignored and not queued. btn_press outside HOLD is ignored.
- Counter widths: step counter 8 bits, hold counter 10 bits. No wrap is possible within the legal parameter ranges.
- text_sel is stable for the entire FADE_IN/HOLD/FADE_OUT period.
- All outputs registered; no combinational input-to-output path.
- Reset asserted mid-sequence: immediate return to PLAY outputs with no restart pulse.

Decomposition:
- Shared package (game_pkg):
  - enum seq_state_t {PLAY, FADE_IN, HOLD, FADE_OUT}
  - text_sel constants TEXT_NONE=2'd0, TEXT_GAME_OVER=2'd1, TEXT_FINAL=2'd2
  - FADE_MAX=4'd15
- One sub-module: frame_tick_gen (DrawX/DrawY edge detector producing frame_tick), reusable by sprite animators.
- Button synchronizer and edge detect stay inline.

Test Plan (STEP_FRAMES=2, HOLD_FRAMES=3; bench drives DrawX/DrawY through full frames):
- Reset check: reset_n low mid-frame -> all outputs 0. Release, sweep 2 frames -> still PLAY, fade_level=0, restart never pulses.
- game_over pulse -> next cycle text_sel=1, overlay_en=1, game_pause=1. fade_level reaches 1 after 2 frame ticks and 15 after 30 ticks.
- game_over and level_done on the same cycle -> text_sel=1. A later level_done during HOLD leaves text_sel=1.
- In HOLD, btn pressed after tick 1 -> stays HOLD. Released, then pressed after tick 3 -> FADE_OUT within 4 cycles of the raw press.
- FADE_OUT from 15 -> fade_level=0 after 30 ticks. Same cycle: overlay_en=0, game_pause=0, text_sel=0, restart high exactly 1 cycle.
- Reset asserted in FADE_OUT at fade_level=7 -> immediate PLAY outputs, restart stays 0. Post-reset level_done -> text_sel=2, fade_level restarts at 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: text overlay sequencer states, text selectors
// and the fade ceiling used by the overlay palette scaler.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } seq_state_t;

  localparam logic [1:0] TEXT_NONE      = 2'd0;
  localparam logic [1:0] TEXT_GAME_OVER = 2'd1;
  localparam logic [1:0] TEXT_FINAL     = 2'd2;

  localparam logic [3:0] FADE_MAX = 4'd15;

endpackage

// File: rtl/frame_tick_gen.sv
// Registered one-cycle pulse on entry to pixel (0,0): one tick per frame.
// Ports: clk, rst_n (async low), draw_x/draw_y in, frame_tick out.
module frame_tick_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       frame_tick
);

  logic at_origin;
  logic origin_q;

  assign at_origin = (draw_x == 10'd0) && (draw_y == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_q   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      origin_q   <= at_origin;
      frame_tick <= at_origin && !origin_q;
    end
  end

endmodule

// File: rtl/text_screen_sequencer.sv
// Full-screen text overlay sequencer: fade in, hold, fade out, restart.
// Ports: vga_clk, reset_n, DrawX/DrawY, game_over, level_done,
// start_btn in; text_sel, overlay_en, fade_level, game_pause, restart out.
module text_screen_sequencer
  import game_pkg::*;
#(
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       game_over,
  input  logic       level_done,
  input  logic       start_btn,
  output logic [1:0] text_sel,
  output logic       overlay_en,
  output logic [3:0] fade_level,
  output logic       game_pause,
  output logic       restart
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [9:0] HOLD_MAX  = 10'(HOLD_FRAMES);

  seq_state_t state;
  logic [7:0] step_cnt;
  logic [9:0] hold_cnt;
  logic       frame_tick;

  logic btn_meta;
  logic btn_sync;
  logic btn_prev;
  logic btn_press;

  logic step_done;

  frame_tick_gen u_tick (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .frame_tick(frame_tick)
  );

  // Press pulse is registered so the raw-to-pulse latency is 3 cycles.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      btn_prev  <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      btn_meta  <= start_btn;
      btn_sync  <= btn_meta;
      btn_prev  <= btn_sync;
      btn_press <= btn_sync && !btn_prev;
    end
  end

  assign step_done = frame_tick && (step_cnt == STEP_LAST);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PLAY;
      step_cnt   <= 8'd0;
      hold_cnt   <= 10'd0;
      text_sel   <= TEXT_NONE;
      overlay_en <= 1'b0;
      fade_level <= 4'd0;
      game_pause <= 1'b0;
      restart    <= 1'b0;
    end else begin
      restart <= 1'b0;
      case (state)
        PLAY: begin
          if (game_over || level_done) begin
            state      <= FADE_IN;
            text_sel   <= game_over ? TEXT_GAME_OVER
                                    : TEXT_FINAL;
            overlay_en <= 1'b1;
            game_pause <= 1'b1;
            fade_level <= 4'd0;
            step_cnt   <= 8'd0;
          end
        end
        FADE_IN: begin
          if (step_done) begin
            step_cnt   <= 8'd0;
            fade_level <= fade_level + 4'd1;
            if (fade_level == FADE_MAX - 4'd1) begin
              state    <= HOLD;
              hold_cnt <= 10'd0;
            end
          end else if (frame_tick) begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (frame_tick && hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 10'd1;
          // Early presses fall through here and are simply lost.
          if (btn_press && hold_cnt == HOLD_MAX) begin
            state    <= FADE_OUT;
            step_cnt <= 8'd0;
          end
        end
        FADE_OUT: begin
          if (step_done) begin
            step_cnt   <= 8'd0;
            fade_level <= fade_level - 4'd1;
            if (fade_level == 4'd1) begin
              state      <= PLAY;
              text_sel   <= TEXT_NONE;
              overlay_en <= 1'b0;
              game_pause <= 1'b0;
              restart    <= 1'b1;
            end
          end else if (frame_tick) begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_text_screen_sequencer.sv
// Scoreboard bench for text_screen_sequencer on a 10x5 pixel frame.
// STEP_FRAMES=2, HOLD_FRAMES=3.
module tb_text_screen_sequencer;
  import game_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       game_over;
  logic       level_done;
  logic       start_btn;
  logic [1:0] text_sel;
  logic       overlay_en;
  logic [3:0] fade_level;
  logic       game_pause;
  logic       restart;

  text_screen_sequencer #(
    .STEP_FRAMES(2),
    .HOLD_FRAMES(3)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .game_over (game_over),
    .level_done(level_done),
    .start_btn (start_btn),
    .text_sel  (text_sel),
    .overlay_en(overlay_en),
    .fade_level(fade_level),
    .game_pause(game_pause),
    .restart   (restart)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t  sb[$];
  sb_t  it;
  int   checks = 0;
  int   errors = 0;
  int   applied = 0;
  int   rcount = 0;
  int   px = 0;
  int   py = 0;
  logic ft_reg = 1'b0;
  logic prev_org = 1'b0;

  always @(negedge vga_clk)
    if (restart === 1'b1) rcount++;

  function automatic logic [8:0] obs();
    return {text_sel, overlay_en, fade_level, game_pause, restart};
  endfunction

  function automatic logic [8:0] mk(logic [1:0] ts, logic ov,
                                    logic [3:0] fd, logic ps,
                                    logic rs);
    return {ts, ov, fd, ps, rs};
  endfunction

  // One clock: bench-side frame tick model, then advance the pixel.
  task automatic cyc();
    logic origin;
    logic cur;
    cur    = ft_reg;
    origin = (DrawX == 10'd0) && (DrawY == 10'd0);
    @(posedge vga_clk);
    if (!reset_n) begin
      ft_reg   = 1'b0;
      prev_org = 1'b0;
    end else begin
      if (cur) applied++;
      ft_reg   = origin && !prev_org;
      prev_org = origin;
    end
    #1;
    px++;
    if (px == 10) begin
      px = 0;
      py = (py == 4) ? 0 : py + 1;
    end
    DrawX = 10'(px);
    DrawY = 10'(py);
  endtask

  task automatic wait_applied(int target);
    int guard;
    guard = 0;
    while (applied < target && guard < 6000) begin
      cyc();
      guard++;
    end
    if (applied < target) begin
      checks++;
      errors++;
      $display("FAIL tick_wait: got %0d ticks, need %0d",
               applied, target);
    end
  endtask

  task automatic test_reset();
    int r0;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (23) cyc();
    reset_n  = 1'b0;
    ft_reg   = 1'b0;
    prev_org = 1'b0;
    #1;
    sb.push_back('{"reset_mid_frame", mk(0, 0, 0, 0, 0)});
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    repeat (3) cyc();
    reset_n = 1'b1;
    r0 = rcount;
    for (int i = 0; i < 100; i++) begin
      sb.push_back('{"reset_idle", mk(0, 0, 0, 0, 0)});
      cyc();
      it = sb.pop_front();
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h",
                 it.name, i, obs(), it.exp);
      end
    end
    cyc();
    checks++;
    if (rcount !== r0) begin
      errors++;
      $display("FAIL reset_no_restart: got %0d want %0d", rcount, r0);
    end
  endtask

  task automatic test_fade_in();
    int   base;
    int   n;
    int   guard;
    logic pend;
    game_over = 1'b1;
    sb.push_back('{"go_enter", mk(TEXT_GAME_OVER, 1, 0, 1, 0)});
    cyc();
    game_over = 1'b0;
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    base  = applied;
    guard = 0;
    while (applied - base < 30 && guard < 4000) begin
      pend = ft_reg;
      if (pend) begin
        n = applied - base + 1;
        sb.push_back('{"fade_in",
                       mk(TEXT_GAME_OVER, 1, 4'(n / 2), 1, 0)});
      end
      cyc();
      guard++;
      if (pend) begin
        it = sb.pop_front();
        checks++;
        if (obs() !== it.exp) begin
          errors++;
          $display("FAIL %s tick %0d: got %h want %h",
                   it.name, applied - base, obs(), it.exp);
        end
      end
    end
    checks++;
    if (dut.state !== HOLD) begin
      errors++;
      $display("FAIL fade_in_hold: got %0d want %0d",
               dut.state, HOLD);
    end
  endtask

  task automatic test_hold_button();
    int hbase;
    hbase = applied;
    wait_applied(hbase + 1);
    start_btn = 1'b1;
    repeat (6) cyc();
    checks++;
    if (dut.state !== HOLD) begin
      errors++;
      $display("FAIL early_press: got %0d want %0d", dut.state, HOLD);
    end
    level_done = 1'b1;
    sb.push_back('{"hold_level_done",
                   mk(TEXT_GAME_OVER, 1, 15, 1, 0)});
    cyc();
    level_done = 1'b0;
    cyc();
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    start_btn = 1'b0;
    repeat (4) cyc();
    wait_applied(hbase + 3);
    repeat (2) cyc();
    start_btn = 1'b1;
    repeat (3) cyc();
    checks++;
    if (dut.state !== HOLD) begin
      errors++;
      $display("FAIL press_3cyc: got %0d want %0d", dut.state, HOLD);
    end
    cyc();
    checks++;
    if (dut.state !== FADE_OUT) begin
      errors++;
      $display("FAIL press_4cyc: got %0d want %0d",
               dut.state, FADE_OUT);
    end
    start_btn = 1'b0;
  endtask

  task automatic test_fade_out();
    int   base;
    int   n;
    int   guard;
    int   r0;
    logic pend;
    base  = applied;
    r0    = rcount;
    guard = 0;
    while (applied - base < 30 && guard < 4000) begin
      pend = ft_reg;
      if (pend) begin
        n = applied - base + 1;
        if (n == 30)
          sb.push_back('{"fade_out_end", mk(0, 0, 0, 0, 1)});
        else
          sb.push_back('{"fade_out",
                         mk(TEXT_GAME_OVER, 1,
                            4'(15 - n / 2), 1, 0)});
      end
      cyc();
      guard++;
      if (pend) begin
        it = sb.pop_front();
        checks++;
        if (obs() !== it.exp) begin
          errors++;
          $display("FAIL %s tick %0d: got %h want %h",
                   it.name, applied - base, obs(), it.exp);
        end
      end
    end
    sb.push_back('{"restart_drop", mk(0, 0, 0, 0, 0)});
    cyc();
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    cyc();
    checks++;
    if (rcount !== r0 + 1) begin
      errors++;
      $display("FAIL restart_count: got %0d want %0d",
               rcount, r0 + 1);
    end
  endtask

  task automatic test_simultaneous_reset();
    int base;
    int r0;
    game_over  = 1'b1;
    level_done = 1'b1;
    sb.push_back('{"both_events", mk(TEXT_GAME_OVER, 1, 0, 1, 0)});
    cyc();
    game_over  = 1'b0;
    level_done = 1'b0;
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    base = applied;
    wait_applied(base + 30);
    cyc();
    sb.push_back('{"both_hold", mk(TEXT_GAME_OVER, 1, 15, 1, 0)});
    level_done = 1'b1;
    cyc();
    level_done = 1'b0;
    cyc();
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    base = applied;
    wait_applied(base + 3);
    repeat (2) cyc();
    start_btn = 1'b1;
    repeat (4) cyc();
    start_btn = 1'b0;
    base = applied;
    wait_applied(base + 16);
    repeat (3) cyc();
    sb.push_back('{"fade_seven", mk(TEXT_GAME_OVER, 1, 7, 1, 0)});
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    r0       = rcount;
    reset_n  = 1'b0;
    ft_reg   = 1'b0;
    prev_org = 1'b0;
    #1;
    sb.push_back('{"reset_in_fade", mk(0, 0, 0, 0, 0)});
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (5) cyc();
    checks++;
    if (rcount !== r0 || restart !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_restart2: got %0d want %0d",
               rcount, r0);
    end
  endtask

  task automatic test_level_done();
    int base;
    level_done = 1'b1;
    sb.push_back('{"ld_enter", mk(TEXT_FINAL, 1, 0, 1, 0)});
    cyc();
    level_done = 1'b0;
    base = applied;
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    game_over = 1'b1;
    sb.push_back('{"ld_ignore_go", mk(TEXT_FINAL, 1, 0, 1, 0)});
    cyc();
    game_over = 1'b0;
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
    wait_applied(base + 2);
    sb.push_back('{"ld_fade_one", mk(TEXT_FINAL, 1, 1, 1, 0)});
    it = sb.pop_front();
    checks++;
    if (obs() !== it.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", it.name, obs(), it.exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    game_over  = 1'b0;
    level_done = 1'b0;
    start_btn  = 1'b0;
    DrawX      = 10'd0;
    DrawY      = 10'd0;
    test_reset();
    test_fade_in();
    test_hold_button();
    test_fade_out();
    test_simultaneous_reset();
    test_level_done();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
